// File: rtl/clk_meter_pkg.sv
// Shared types and width helpers for the slow-clock period meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_meter_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STOPPED = 2'd2
  } state_t;

  // Largest supported averaging exponent (16 periods per result)
  localparam int AVG_LOG2_MAX = 4;

  // Accumulator must hold 2^avg_log2 full-scale samples without wrapping
  function automatic int acc_width(input int cnt_w, input int avg_log2);
    return cnt_w + avg_log2;
  endfunction

endpackage

// File: rtl/sync_rise.sv
// 2-FF synchronizer for an asynchronous input followed by a rising-edge detector.
// Latency: rise pulses 2-3 clkin cycles after the input rises (one cycle wide).
// Backpressure: none; free-running.
module sync_rise (
  input  logic clkin,
  input  logic rstn,
  input  logic d,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rise = r_sync & ~r_prev;

endmodule

// File: rtl/clk_meter.sv
// Measures the period of an asynchronous slow signal in clkin cycles, averaged over 2^AVG_LOG2 periods.
// Latency: period_valid rises one cycle after the edge that closes an averaging window.
// Backpressure: single output register; an unaccepted result is overwritten and flagged by sticky overrun.
module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             sig,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overrun,
  output logic             stopped
);

  localparam int                ACC_W     = acc_width(CNT_W, AVG_LOG2);
  localparam int                NS_W      = AVG_LOG2 + 1;
  localparam logic [NS_W-1:0]   LAST_SAMP = NS_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  TMO       = CNT_W'(TIMEOUT_CYC);

  logic             w_edge;
  logic             w_timeout;
  logic             w_load;
  logic             w_xfer;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_result;

  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [NS_W-1:0]  r_nsamp;
  state_t           r_state;

  sync_rise u_sync_rise (
    .clkin (clkin),
    .rstn  (rstn),
    .d     (sig),
    .rise  (w_edge)
  );

  assign w_timeout = (r_cnt == TMO);
  assign w_sum     = r_acc + ACC_W'(r_cnt);
  assign w_result  = CNT_W'(w_sum >> AVG_LOG2);
  assign w_load    = (r_state == ST_MEASURE) && w_edge && (r_nsamp == LAST_SAMP);
  assign w_xfer    = period_valid && period_ready;

  // Per-period counter: restarts at 1 on each edge, saturates at the timeout so a dead input stays flagged
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= CNT_W'(1);
    end else if (!w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Measurement FSM: arming edge opens a window, windows run back-to-back, timeout discards the partial window
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_ARM;
      r_acc   <= '0;
      r_nsamp <= '0;
      stopped <= 1'b0;
    end else begin
      case (r_state)
        ST_ARM: begin
          if (w_edge) begin
            r_state <= ST_MEASURE;
            r_acc   <= '0;
            r_nsamp <= '0;
          end else if (w_timeout) begin
            r_state <= ST_STOPPED;
            stopped <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (w_edge) begin
            if (r_nsamp == LAST_SAMP) begin
              r_acc   <= '0;
              r_nsamp <= '0;
            end else begin
              r_acc   <= w_sum;
              r_nsamp <= r_nsamp + NS_W'(1);
            end
          end else if (w_timeout) begin
            r_state <= ST_STOPPED;
            r_acc   <= '0;
            r_nsamp <= '0;
            stopped <= 1'b1;
          end
        end
        ST_STOPPED: begin
          if (w_edge) begin
            r_state <= ST_MEASURE;
            r_acc   <= '0;
            r_nsamp <= '0;
            stopped <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_ARM;
          r_acc   <= '0;
          r_nsamp <= '0;
          stopped <= 1'b0;
        end
      endcase
    end
  end

  // Output register: a new result always wins; overrun marks a result lost before it was taken
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      period       <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (w_load) begin
      period       <= w_result;
      period_valid <= 1'b1;
      if (period_valid && !period_ready) begin
        overrun <= 1'b1;
      end
    end else if (w_xfer) begin
      period_valid <= 1'b0;
      overrun      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_meter.sv
module tb_clk_meter;

  logic        clkin;
  logic        rstn;
  logic        sig_a;
  logic        sig_b;
  logic        ready_a;
  logic        ready_b;
  logic [31:0] period_a;
  logic [31:0] period_b;
  logic        valid_a;
  logic        valid_b;
  logic        overrun_a;
  logic        overrun_b;
  logic        stopped_a;
  logic        stopped_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_a[$];
  int exp_b[$];
  int pop_cyc[$];
  int c0;

  clk_meter #(.CNT_W(32), .AVG_LOG2(2), .TIMEOUT_CYC(100)) u_dut_a (
    .clkin        (clkin),
    .rstn         (rstn),
    .sig          (sig_a),
    .period       (period_a),
    .period_valid (valid_a),
    .period_ready (ready_a),
    .overrun      (overrun_a),
    .stopped      (stopped_a)
  );

  clk_meter #(.CNT_W(32), .AVG_LOG2(0), .TIMEOUT_CYC(100)) u_dut_b (
    .clkin        (clkin),
    .rstn         (rstn),
    .sig          (sig_b),
    .period       (period_b),
    .period_valid (valid_b),
    .period_ready (ready_b),
    .overrun      (overrun_b),
    .stopped      (stopped_b)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the averaging instance
  always @(negedge clkin) begin
    #1;
    if (rstn && valid_a && ready_a) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_a: got %0d expected none", period_a);
      end else begin
        chk("result_a", period_a, exp_a.pop_front());
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Scoreboard monitor for the non-averaging instance
  always @(negedge clkin) begin
    #1;
    if (rstn && valid_b && ready_b) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_b: got %0d expected none", period_b);
      end else begin
        chk("result_b", period_b, exp_b.pop_front());
      end
    end
  end

  task automatic set_sig(input bit b, input logic v);
    if (b) sig_b = v;
    else   sig_a = v;
  endtask

  // n periods of length p, each starting with a rising edge on the current negedge
  task automatic run(input int p, input int n, input bit b);
    for (int i = 0; i < n; i++) begin
      set_sig(b, 1'b1);
      repeat (p / 2) @(negedge clkin);
      set_sig(b, 1'b0);
      repeat (p - p / 2) @(negedge clkin);
    end
  endtask

  task automatic do_reset();
    @(negedge clkin);
    rstn = 1'b0;
    repeat (2) @(negedge clkin);
    rstn = 1'b1;
  endtask

  initial begin
    rstn    = 1'b1;
    sig_a   = 1'b0;
    sig_b   = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;

    // Reset values
    @(negedge clkin);
    rstn = 1'b0;
    #1;
    chk("rst_period", period_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_overrun", overrun_a, 0);
    chk("rst_stopped", stopped_a, 0);
    @(negedge clkin);
    @(negedge clkin);
    rstn = 1'b1;

    // Test 1: constant period 10, results every 40 cycles
    exp_a.push_back(10);
    exp_a.push_back(10);
    exp_a.push_back(10);
    @(negedge clkin);
    c0 = cyc;
    run(10, 13, 1'b0);
    repeat (5) @(negedge clkin);
    if (pop_cyc.size() == 3) begin
      checks++;
      if ((pop_cyc[0] - c0) < 42 || (pop_cyc[0] - c0) > 44) begin
        errors++;
        $display("FAIL first_latency: got %0d expected 42..44", pop_cyc[0] - c0);
      end
      chk("gap_1_2", pop_cyc[1] - pop_cyc[0], 40);
      chk("gap_2_3", pop_cyc[2] - pop_cyc[1], 40);
    end else begin
      chk("t1_result_count", pop_cyc.size(), 3);
    end

    // Test 2: alternating 9/12 truncates to 10, then constant 16
    do_reset();
    exp_a.push_back(10);
    exp_a.push_back(16);
    run(9, 1, 1'b0);
    run(12, 1, 1'b0);
    run(9, 1, 1'b0);
    run(12, 1, 1'b0);
    run(16, 5, 1'b0);

    // Test 3: input stops, timeout, restart
    do_reset();
    exp_a.push_back(10);
    exp_a.push_back(10);
    run(10, 9, 1'b0);
    repeat (85) @(negedge clkin);
    #1;
    chk("stopped_early", stopped_a, 0);
    repeat (15) @(negedge clkin);
    #1;
    chk("stopped_set", stopped_a, 1);
    chk("stopped_no_valid", valid_a, 0);
    @(negedge clkin);
    exp_a.push_back(10);
    run(10, 5, 1'b0);
    #1;
    chk("stopped_cleared", stopped_a, 0);
    @(negedge clkin);

    // Test 4: overrun across two windows
    do_reset();
    ready_a = 1'b0;
    run(10, 4, 1'b0);
    run(20, 5, 1'b0);
    #1;
    chk("ovr_period", period_a, 20);
    chk("ovr_valid", valid_a, 1);
    chk("ovr_flag", overrun_a, 1);
    exp_a.push_back(20);
    @(negedge clkin);
    ready_a = 1'b1;
    @(negedge clkin);
    ready_a = 1'b0;
    #2;
    chk("xfer_valid", valid_a, 0);
    chk("xfer_overrun", overrun_a, 0);

    // Test 5: reset mid-window discards earlier samples
    do_reset();
    ready_a = 1'b0;
    run(10, 7, 1'b0);
    #1;
    chk("pre_rst_valid", valid_a, 1);
    chk("pre_rst_period", period_a, 10);
    @(negedge clkin);
    rstn = 1'b0;
    #1;
    chk("mid_rst_period", period_a, 0);
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_overrun", overrun_a, 0);
    chk("mid_rst_stopped", stopped_a, 0);
    @(negedge clkin);
    @(negedge clkin);
    rstn = 1'b1;
    ready_a = 1'b1;
    exp_a.push_back(13);
    run(13, 5, 1'b0);

    // Test 6: no averaging, period 4 at the input limit
    do_reset();
    for (int i = 0; i < 5; i++) exp_b.push_back(4);
    run(4, 6, 1'b1);

    repeat (20) @(negedge clkin);
    chk("queue_a_drained", exp_a.size(), 0);
    chk("queue_b_drained", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_meter.md
# clk_meter

Measures the period of a slow, asynchronous clock or square wave `sig` in units of the system clock `clkin`, averaged over 2^AVG_LOG2 periods. It is the receiving counterpart of the design's clock generators: it checks their output frequency in self-test, and it monitors externally supplied slow clocks. Results leave through a valid/ready register. A timeout flags a stopped input.

## Interface
- `CNT_W`, 32: width of the per-period counter and of `period`.
- `AVG_LOG2`, 2: log2 of the number of periods averaged per result. Range 0..4.
- `TIMEOUT_CYC`, 50000000: clkin cycles without a rising edge before the input is declared stopped. Must be < 2^CNT_W.
- `clkin` in 1: system clock. All logic is in this single clock domain.
- `rstn` in 1: asynchronous, active-low reset.
- `sig` in 1: measured signal. Asynchronous to clkin.
- `period` out CNT_W: averaged period in clkin cycles. Held stable while `period_valid` is high.
- `period_valid` out 1: result available.
- `period_ready` in 1: consumer accepts the result.
- `overrun` out 1: a result was overwritten before it was accepted.
- `stopped` out 1: no rising edge seen for TIMEOUT_CYC cycles.

## Operation
- **Synchronization:** `sig` passes through a 2-FF synchronizer, then a rising-edge detector. `edge` is a one-cycle pulse.
- **Per-period counter `cnt`:**
  - On `edge`, the sample is the value of `cnt`, and `cnt` loads 1.
  - Otherwise `cnt` increments, saturating at TIMEOUT_CYC.
  - The sample is exactly the number of clkin cycles between consecutive detected edges. Example: sig period 10 gives sample 10.
- **Accumulator:** width CNT_W+AVG_LOG2. It sums 2^AVG_LOG2 samples. Result = sum >> AVG_LOG2, truncated.
- **FSM states:**
  - ARM: after reset or restart. Waits for the first `edge`. That edge starts the window and is not counted as a sample. On `edge` → MEASURE, with acc=0, nsamp=0, `cnt`=1.
  - MEASURE: each `edge` adds the sample to acc and increments nsamp. On the 2^AVG_LOG2-th sample, the result loads into the output register and acc/nsamp clear. The state stays MEASURE, so windows are back-to-back and the closing edge opens the next window.
  - STOPPED: entered from ARM or MEASURE when `cnt` reaches TIMEOUT_CYC. The partial window is discarded and `stopped`=1. On `edge` → MEASURE, with `stopped` cleared in the same cycle, and that edge opens a new window.
- **Output register:**
  - A load sets `period_valid`=1.
  - A transfer occurs when `period_valid` && `period_ready`. It clears `period_valid` at the next edge, unless a new load happens in the same cycle; then `period_valid` stays 1 with the new value.
  - If a load occurs while `period_valid`=1 and no transfer happens: the register takes the new value and `overrun` sets.
  - `overrun` is sticky and clears on the next transfer. If that transfer cycle also carries an overwriting load, `overrun` stays 1.
- **Input limits:**
  - `sig` high and low phases must each be ≥2 clkin cycles, i.e. period ≥4.
  - Faster input gives undefined values but must never lock the FSM.
  - An input that is stuck high or stuck low times out into STOPPED.

## Timing
- Reset values: `period`=0, `period_valid`=0, `overrun`=0, `stopped`=0, state ARM, synchronizer FFs 0.
- Edge latency: a rising edge on `sig` produces `edge` 2–3 clkin cycles later, due to synchronizer uncertainty. The measured period therefore has ±1 cycle jitter per sample.
- Result latency: `period_valid` rises one cycle after the edge that completes the window, i.e. on the registered load.
- Timeout: `stopped` rises one cycle after `cnt` reaches TIMEOUT_CYC. `period_valid` and `period` are not affected, and a pending result remains pending.
- Reset mid-window: everything returns to reset values immediately (asynchronously). Measurement restarts from ARM.

## Structure
- `clk_meter_pkg`: FSM state enum (ARM, MEASURE, STOPPED) and the accumulator-width localparam helper.
- Sub-module `sync_rise`: 2-FF synchronizer plus rising-edge detector. Ports are `clkin`, `rstn`, `d`, `rise`. It is reused by other async-input blocks.
- Remaining logic (counter, accumulator, FSM, output register) lives in `clk_meter`.

## Test plan
1. AVG_LOG2=2, sig period 10 (5 high / 5 low), `period_ready`=1 → first `period_valid` ≈ 40 cycles after the first edge. Then `period`=10, with results every 40 cycles.
2. Alternating periods 9, 12, 9, 12 → sum 42 → `period`=10 (truncated). Then change to a constant 16 → next full window gives `period`=16.
3. TIMEOUT_CYC=100; run sig at period 10, then hold it low → `stopped`=1 about 100 cycles after the last detected edge, with no new `period_valid`. Restart sig → `stopped` clears on the first detected edge, and the next result arrives 4 periods later.
4. `period_ready`=0 across two windows (periods 10, then 20) → `period`=20, `period_valid`=1, `overrun`=1. Pulse `period_ready` → `period_valid`=0 and `overrun`=0 on the next cycle.
5. Assert `rstn` low mid-window (after 2 samples) → all outputs are 0 immediately. After release, the first result takes a full 4-period window and does not include pre-reset samples.
6. AVG_LOG2=0, sig period 4 (the limit) → every edge yields a result of 4, with one-cycle jitter (3..5) only when `sig` edges are placed asynchronously.
